imem_loader: RTL

Boot-time program loader that sits upstream of the pipelined MIPS core. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. It writes those words into the instruction memory's write port and holds the core in reset until a complete, checksum-verified image has been stored. A malformed image parks the block in an error state, and the core stays in reset.

---
 rtl/imem_loader.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Brief    : Boot-time loader. Takes a byte stream (16-bit big-endian word
//            count, 4*N big-endian data bytes, XOR checksum byte), writes the
//            assembled 32-bit words into the instruction memory and holds the
//            MIPS core in reset until a verified image has been stored.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_rst,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           words_loaded
);

    typedef enum logic [2:0] {
        ST_HDR0 = 3'd0,
        ST_HDR1 = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    // One bit wider than the header so that DEPTH = 65536 is representable.
    localparam logic [16:0] c_depth = 17'(DEPTH);

    state_t                  state_q, state_d;
    logic [15:0]             count_q, count_d;         // N from the header
    logic [7:0]              xor_q, xor_d;             // running XOR of accepted bytes
    logic [1:0]              byte_cnt_q, byte_cnt_d;   // byte within current word
    logic [ADDR_WIDTH-1:0]   word_idx_q, word_idx_d;   // index of the word being assembled
    logic [23:0]             shift_q, shift_d;         // first three bytes of the word
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [15:0]             words_loaded_q, words_loaded_d;

    logic                    w_ready;
    logic                    w_accept;
    logic [15:0]             w_hdr_n;

    // Ready depends only on the state; terminal states refuse all input.
    always_comb begin
        w_ready  = (state_q == ST_HDR0) || (state_q == ST_HDR1) ||
                   (state_q == ST_DATA) || (state_q == ST_CSUM);
        w_accept = in_valid && w_ready;
        w_hdr_n  = {count_q[15:8], in_data};
    end

    // Next-state and datapath updates, applied only on an accepted byte.
    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        xor_d          = xor_q;
        byte_cnt_d     = byte_cnt_q;
        word_idx_d     = word_idx_q;
        shift_d        = shift_q;
        we_d           = 1'b0;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        words_loaded_d = words_loaded_q;
        if (w_accept) begin
            xor_d = xor_q ^ in_data;
            case (state_q)
                ST_HDR0: begin
                    count_d = {in_data, 8'h00};
                    state_d = ST_HDR1;
                end
                ST_HDR1: begin
                    count_d = w_hdr_n;
                    if ((w_hdr_n == 16'd0) || ({1'b0, w_hdr_n} > c_depth)) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    shift_d    = {shift_q[15:0], in_data};
                    if (byte_cnt_q == 2'd3) begin
                        we_d           = 1'b1;
                        addr_d         = word_idx_q;
                        wdata_d        = {shift_q, in_data};
                        words_loaded_d = words_loaded_q + 16'd1;
                        // The index is not advanced past the last word, so
                        // it never wraps even when N equals DEPTH.
                        if (words_loaded_d == count_q) begin
                            state_d = ST_CSUM;
                        end else begin
                            word_idx_d = word_idx_q + ADDR_WIDTH'(1);
                        end
                    end
                end
                ST_CSUM: begin
                    if ((xor_q ^ in_data) == 8'h00) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_HDR0;
            count_q        <= 16'd0;
            xor_q          <= 8'h00;
            byte_cnt_q     <= 2'd0;
            word_idx_q     <= '0;
            shift_q        <= 24'd0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= 32'd0;
            words_loaded_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            xor_q          <= xor_d;
            byte_cnt_q     <= byte_cnt_d;
            word_idx_q     <= word_idx_d;
            shift_q        <= shift_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            words_loaded_q <= words_loaded_d;
        end
    end

    // Status outputs decoded from the state; the core leaves reset only in DONE.
    always_comb begin
        in_ready     = w_ready;
        imem_we      = we_q;
        imem_addr    = addr_q;
        imem_wdata   = wdata_q;
        words_loaded = words_loaded_q;
        done         = (state_q == ST_DONE);
        error        = (state_q == ST_ERR);
        cpu_rst      = (state_q != ST_DONE);
    end

endmodule
`default_nettype wire
